i2c_master: RTL and testbench
=============================

// Module: i2c_master
// PURPOSE
//  Single-byte I2C controller (initiator): drives the bus that the i2c target block answers on.
//  Per command: START, 7-bit address + R/W, one data byte written or read, STOP.
//  Open-drain pads: *_o=0 pulls the line low, *_o=1 releases it; top level maps ~*_o to uio_oe.
// PARAMETERS
//  CLK_DIV  4  clk cycles per quarter SCL period (SCL period = 4*CLK_DIV); legal range >=2
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  scl_i      in   1  sampled SCL line
//  scl_o      out  1  SCL drive (0 = pull low, 1 = release)
//  sda_i      in   1  sampled SDA line
//  sda_o      out  1  SDA drive (0 = pull low, 1 = release)
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_addr   in   7  target address
//  cmd_rw     in   1  0 = write, 1 = read
//  cmd_wdata  in   8  write byte, captured at accept
//  rd_data    out  8  read byte, valid with done; held until next read
//  done       out  1  one-cycle pulse at transaction end
//  ack_err    out  1  set with done if address or write-data NACKed; held until next accept
//  busy       out  1  high from accept until done
// BEHAVIOUR
//  Reset: scl_o=1, sda_o=1, cmd_ready=1, busy=0, done=0, ack_err=0, rd_data=0, state IDLE.
//  Timebase: quarter counter 0..CLK_DIV-1; all phase changes on quarter boundaries.
//  States: IDLE -> START -> ADDR(8 bits) -> AACK -> DATA(8 bits) -> DACK -> STOP -> IDLE.
//  START (4q): q0-1 SCL=1 SDA=1; q2-3 SCL=1 SDA=0.
//  Bit slot (4q): q0 SCL=0 and SDA updated; q1 SCL=0; q2-3 SCL=1; sample sda_i at end of q2.
//  Bits sent MSB first; address byte = {cmd_addr, cmd_rw}.
//  AACK/DACK: master releases SDA (write) and samples; sda_i=1 -> NACK.
//  Read DATA: SDA released, 8 samples shifted MSB first; DACK driven by master as NACK (SDA=1).
//  STOP (4q): q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2-3 SCL=1 SDA=1.
//  Address NACK: skip DATA/DACK, go to STOP, ack_err=1.
//  Full transaction = 80 quarters; done pulses in the cycle after the last STOP quarter,
//  i.e. 80*CLK_DIV cycles after the accept cycle; cmd_ready=1 same cycle as done.
//  Address-NACK transaction = 44 quarters.
//  cmd_valid while busy: ignored, no queueing. cmd_* sampled only at accept.
//  Reset mid-transaction: both lines released next edge, no STOP generated, state IDLE.
//  No arbitration or multi-master detection; sda_i ignored outside sample points.
// CONFIGURATION
//  I2C_STRETCH_EN defined: after releasing SCL (q2 entry), quarter counter freezes while
//   scl_i=0; timing resumes the cycle after scl_i reads 1 (target clock stretching).
//  Not defined: scl_i unused; timing purely counter-based.
// TESTING
//  Reset, CLK_DIV=4: write addr 0x50 data 0xA5, target ACKs -> SDA bits 1010000 0 A 10100101 A, done @ 320 cycles, ack_err=0.
//  Address 0x21 write, no target (SDA pulled up) -> ack_err=1, STOP after 9th bit, done @ 176 cycles.
//  Read addr 0x50, target returns 0x3C -> rd_data=0x3C, 9th data bit SDA released (NACK), ack_err=0.
//  With I2C_STRETCH_EN, target holds SCL low 10 cycles in addr bit 3 -> done @ 330; without: done @ 320.
//  Assert reset at data bit 4 -> next cycle scl_o=1, sda_o=1, busy=0, cmd_ready=1; new command runs normally.
//  cmd_valid held high through a transaction with different cmd_addr -> ignored until IDLE, then back-to-back accept.

Source files
------------

// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
// Single-byte I2C initiator. Each accepted command produces START, the
// address byte {cmd_addr, cmd_rw}, one data byte (written or read) and STOP.
// Both pads are open-drain style: *_o = 0 pulls the line low and *_o = 1
// releases it.
//
// Parameters
//   CLK_DIV    clk cycles per quarter SCL period (>= 2)
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   scl_i      sampled SCL line (used only for clock stretching)
//   scl_o      SCL drive, 0 = pull low, 1 = release
//   sda_i      sampled SDA line
//   sda_o      SDA drive, 0 = pull low, 1 = release
//   cmd_valid  command request
//   cmd_ready  high only while idle; accept = cmd_valid & cmd_ready
//   cmd_addr   7-bit target address, captured at accept
//   cmd_rw     0 = write, 1 = read, captured at accept
//   cmd_wdata  write byte, captured at accept
//   rd_data    read byte, updated with done of a completed read
//   done       one-cycle pulse at transaction end
//   ack_err    address or write-data NACK seen; valid with done,
//              held until the next accept
//   busy       high from accept until done
//
// Optional feature
//   I2C_STRETCH_EN  when defined, the quarter timer freezes in the SCL-high
//                   phase of every bit slot while scl_i reads 0, so a target
//                   may stretch the clock. When undefined, scl_i is unused.
// ---------------------------------------------------------------------------
//
// state | meaning
// IDLE  | lines released, waiting for a command
// START | 4 quarters: SDA falls while SCL is high
// ADDR  | 8 bit slots, address byte MSB first
// AACK  | address acknowledge slot, SDA released and sampled
// DATA  | 8 bit slots, write byte driven or read byte sampled
// DACK  | data acknowledge slot; sampled on write, NACK driven on read
// STOP  | 4 quarters: SDA rises while SCL is high
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    output logic       scl_o,
    input  logic       sda_i,
    output logic       sda_o,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       ack_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        AACK,
        DATA,
        DACK,
        STOP
    } state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state;
    logic [1:0]    quarter;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    wdata_q;
    logic          rw_q;
    logic          samp;
    logic          err_q;
    logic          addr_nack;

    logic          accept;
    logic          slot_state;
    logic          hold;
    logic          tick;

    state_t        state_n;
    logic [1:0]    quarter_n;
    logic [2:0]    bit_cnt_n;
    logic [7:0]    shreg_n;

    assign accept     = cmd_valid & cmd_ready;
    assign slot_state = (state == ADDR) || (state == AACK) ||
                        (state == DATA) || (state == DACK);

`ifdef I2C_STRETCH_EN
    // SCL is released on entry to q2; a target holding it low freezes time.
    assign hold = slot_state && (quarter == 2'd2) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    // End of the current quarter.
    assign tick = (state != IDLE) && (div_cnt == '0) && !hold;

    // Line levels {scl, sda} for a given state/quarter. b is the current
    // outgoing bit; rd releases SDA through the whole read data byte.
    function automatic logic [1:0] lines(input state_t s, input logic [1:0] q,
                                         input logic b, input logic rd);
        logic [1:0] r;
        r = 2'b11;
        case (s)
            IDLE:       r = 2'b11;
            START:      r = {1'b1, ~q[1]};
            ADDR:       r = {q[1], b};
            AACK, DACK: r = {q[1], 1'b1};
            DATA:       r = {q[1], rd | b};
            STOP:       r = {q != 2'd0, q[1]};
            default:    r = 2'b11;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n   = state;
        quarter_n = quarter;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        if (state == IDLE) begin
            if (accept) begin
                state_n   = START;
                quarter_n = 2'd0;
                shreg_n   = {cmd_addr, cmd_rw};
            end
        end else if (tick) begin
            if (quarter != 2'd3) begin
                quarter_n = quarter + 2'd1;
            end else begin
                quarter_n = 2'd0;
                case (state)
                    START: begin
                        state_n   = ADDR;
                        bit_cnt_n = 3'd7;
                    end
                    ADDR: begin
                        shreg_n = {shreg[6:0], samp};
                        if (bit_cnt == 3'd0) state_n = AACK;
                        else                 bit_cnt_n = bit_cnt - 3'd1;
                    end
                    AACK: begin
                        if (samp) begin
                            state_n = STOP;
                        end else begin
                            state_n   = DATA;
                            bit_cnt_n = 3'd7;
                            shreg_n   = wdata_q;
                        end
                    end
                    DATA: begin
                        // Write: shifts the next bit to the top.
                        // Read: accumulates samples MSB first.
                        shreg_n = {shreg[6:0], samp};
                        if (bit_cnt == 3'd0) state_n = DACK;
                        else                 bit_cnt_n = bit_cnt - 3'd1;
                    end
                    DACK:    state_n = STOP;
                    STOP:    state_n = IDLE;
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            quarter   <= 2'd0;
            div_cnt   <= DIV_LAST;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            wdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            samp      <= 1'b1;
            err_q     <= 1'b0;
            addr_nack <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            rd_data   <= 8'h00;
        end else begin
            state          <= state_n;
            quarter        <= quarter_n;
            bit_cnt        <= bit_cnt_n;
            shreg          <= shreg_n;
            {scl_o, sda_o} <= lines(state_n, quarter_n, shreg_n[7], rw_q);
            done           <= 1'b0;

            if (state == IDLE)
                div_cnt <= DIV_LAST;
            else if (!hold)
                div_cnt <= (div_cnt == '0) ? DIV_LAST : div_cnt - 1'b1;

            if (accept) begin
                wdata_q   <= cmd_wdata;
                rw_q      <= cmd_rw;
                err_q     <= 1'b0;
                addr_nack <= 1'b0;
                ack_err   <= 1'b0;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
            end

            // SDA is only looked at in the last cycle of the SCL-high q2.
            if (tick && slot_state && (quarter == 2'd2))
                samp <= sda_i;

            if (tick && (quarter == 2'd3)) begin
                case (state)
                    AACK: begin
                        if (samp) begin
                            err_q     <= 1'b1;
                            addr_nack <= 1'b1;
                        end
                    end
                    DACK: begin
                        if (!rw_q && samp) err_q <= 1'b1;
                    end
                    STOP: begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        ack_err   <= err_q;
                        if (rw_q && !addr_nack) rd_data <= shreg;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
module tb_i2c_master;

    localparam int CD = 4;
`ifdef I2C_STRETCH_EN
    localparam int STRETCH_EXTRA = 10;
`else
    localparam int STRETCH_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_i, scl_o, sda_i, sda_o;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] rd_data;
    logic       done, ack_err, busy;

    // target side of the wired-AND bus
    logic t_sda = 1'b1;
    logic t_hold = 1'b0;
    assign scl_i = scl_o & ~t_hold;
    assign sda_i = sda_o & t_sda;

    i2c_master #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset),
        .scl_i(scl_i), .scl_o(scl_o), .sda_i(sda_i), .sda_o(sda_o),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .rd_data(rd_data),
        .done(done), .ack_err(ack_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- target model ----------------
    bit         t_ack_addr = 1'b1;
    bit         t_ack_data = 1'b1;
    bit         t_rd = 1'b0;
    bit         t_stretch = 1'b0;
    bit         stretch_done = 1'b0;
    logic [7:0] t_rdbyte = 8'h00;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    int         tcnt = 0;
    int         hcnt = 0;
    bit         hup = 1'b0;

    // Counts SCL rising edges since START; on each falling edge sets the
    // target SDA for the upcoming slot (slot 8 = addr ack, 9..16 data,
    // 17 data ack).
    always @(negedge clk) begin
        if (scl_o && scl_prev && sda_prev && !sda_i) begin
            tcnt = 0;
        end else if (!scl_prev && scl_o) begin
            tcnt++;
        end else if (scl_prev && !scl_o) begin
            if (tcnt == 8)                    t_sda = t_ack_addr ? 1'b0 : 1'b1;
            else if (tcnt >= 9 && tcnt <= 16) t_sda = t_rd ? t_rdbyte[16 - tcnt] : 1'b1;
            else if (tcnt == 17)              t_sda = (!t_rd && t_ack_data) ? 1'b0 : 1'b1;
            else                              t_sda = 1'b1;
            if (tcnt == 3 && t_stretch && !stretch_done) begin
                t_hold = 1'b1;
                hcnt   = 0;
                hup    = 1'b0;
            end
        end
        if (t_hold) begin
            if (scl_o) hup = 1'b1;
            if (hup) begin
                if (hcnt == 10) begin
                    t_hold       = 1'b0;
                    stretch_done = 1'b1;
                end else begin
                    hcnt++;
                end
            end
        end
        scl_prev = scl_o;
        sda_prev = sda_i;
    end

    // ---------------- quarter-level reference model ----------------
    logic [1:0]  expq [0:79];
    int          nq = 80;
    int          cyc = 0;
    int          acc = -1000;
    bit          chk_on = 1'b0;
    bit          chk_en = 1'b1;
    logic [17:0] busv = '0;

    task automatic build_model(input logic [6:0] a, input logic rw,
                               input logic [7:0] wd, input bit aack);
        logic [7:0] ab;
        logic       l;
        int         i;
        ab = {a, rw};
        expq[0] = 2'b11; expq[1] = 2'b11; expq[2] = 2'b10; expq[3] = 2'b10;
        i = 4;
        for (int s = 0; s < 9; s++) begin
            l = (s < 8) ? ab[7 - s] : 1'b1;
            expq[i] = {1'b0, l}; expq[i+1] = {1'b0, l};
            expq[i+2] = {1'b1, l}; expq[i+3] = {1'b1, l};
            i += 4;
        end
        if (aack) begin
            for (int s = 0; s < 9; s++) begin
                l = (s < 8) ? (rw | wd[7 - s]) : 1'b1;
                expq[i] = {1'b0, l}; expq[i+1] = {1'b0, l};
                expq[i+2] = {1'b1, l}; expq[i+3] = {1'b1, l};
                i += 4;
            end
        end
        expq[i] = 2'b00; expq[i+1] = 2'b10; expq[i+2] = 2'b11; expq[i+3] = 2'b11;
        nq = i + 4;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            chk_on = 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            acc = cyc;
            build_model(cmd_addr, cmd_rw, cmd_wdata, t_ack_addr);
            busv   = '0;
            chk_on = chk_en;
        end
    end

    // Per-cycle compare: k cycles after the accept edge the outputs show
    // quarter k/CD; done appears at k = nq*CD.
    always @(negedge clk) begin : cmp
        int         k;
        int         qi;
        logic [1:0] e;
        if (chk_on) begin
            k  = cyc - acc;
            qi = k / CD;
            if (k < nq * CD) begin
                e = expq[qi];
                chk("lines", {27'd0, scl_o, sda_o, done, busy, cmd_ready}, {27'd0, e, 3'b010});
                if ((k % CD) == CD - 1 && qi >= 4 && qi < nq - 4 && (qi % 4) == 2)
                    busv[17 - (qi - 4) / 4] = sda_i;
            end else begin
                chk("done_cycle", {27'd0, scl_o, sda_o, done, busy, cmd_ready}, 32'b11101);
                chk_on = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] wd);
        @(negedge clk);
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles", budget);
            lat = -1;
        end else begin
            lat = cyc - acc;
        end
    endtask

    initial begin
        int lat;
        int acc1;

        repeat (3) @(negedge clk);
        chk("rst_scl", scl_o, 1);
        chk("rst_sda", sda_o, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // write 0x50 <- 0xA5, target ACKs
        send(7'h50, 1'b0, 8'hA5);
        wait_done(400, lat);
        chk("wr_latency", lat, 320);
        chk("wr_ack_err", ack_err, 0);
        chk("wr_bus_bits", busv, 18'b10100000_0_10100101_0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // no target at 0x21
        t_ack_addr = 1'b0;
        send(7'h21, 1'b0, 8'h00);
        wait_done(400, lat);
        chk("nack_latency", lat, 176);
        chk("nack_ack_err", ack_err, 1);
        repeat (5) @(negedge clk);
        chk("nack_err_held", ack_err, 1);

        // read 0x50, target returns 0x3C
        t_ack_addr = 1'b1;
        t_rd       = 1'b1;
        t_rdbyte   = 8'h3C;
        send(7'h50, 1'b1, 8'h00);
        wait_done(400, lat);
        chk("rd_latency", lat, 320);
        chk("rd_ack_err", ack_err, 0);
        chk("rd_data", rd_data, 8'h3C);
        chk("rd_bus_bits", busv, 18'b10100001_0_00111100_1);

        // write with data NACK
        t_rd       = 1'b0;
        t_ack_data = 1'b0;
        send(7'h2A, 1'b0, 8'h5A);
        wait_done(400, lat);
        chk("dnack_latency", lat, 320);
        chk("dnack_ack_err", ack_err, 1);
        chk("rd_data_held", rd_data, 8'h3C);

        // target stretches SCL for 10 cycles in address bit 3
        t_ack_data   = 1'b1;
        t_stretch    = 1'b1;
        stretch_done = 1'b0;
        chk_en       = 1'b0;
        send(7'h50, 1'b0, 8'hA5);
        wait_done(400, lat);
        chk("stretch_latency", lat, 320 + STRETCH_EXTRA);
        chk("stretch_ack_err", ack_err, 0);
        t_stretch = 1'b0;
        chk_en    = 1'b1;
        repeat (12) @(negedge clk);

        // reset in the middle of data bit 4
        send(7'h50, 1'b0, 8'hA5);
        repeat (226) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_lines", {scl_o, sda_o}, 2'b11);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_done", done, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send(7'h50, 1'b0, 8'h3C);
        wait_done(400, lat);
        chk("post_rst_latency", lat, 320);
        chk("post_rst_ack_err", ack_err, 0);

        // cmd_valid held through a transaction, fields change while busy
        @(negedge clk);
        cmd_addr  = 7'h50;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h11;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_addr  = 7'h33;
        cmd_wdata = 8'h77;
        repeat (20) @(negedge clk);
        chk("busy_ignored_ready", cmd_ready, 0);
        acc1 = acc;
        wait_done(400, lat);
        chk("b2b_first_latency", lat, 320);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_accept_gap", acc - acc1, 321);
        chk("b2b_busy", busy, 1);
        wait_done(400, lat);
        chk("b2b_second_latency", lat, 320);
        chk("b2b_ack_err", ack_err, 0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
